// File: rtl/encoder_8_to_3_scanner_if.sv
// ----------------------------------------------------------------------------
// encoder_8_to_3_scanner_if
// Bundles the request-side and index-side handshake signals of the
// sequential priority encoder.
//   req / req_valid / req_ready : request vector handshake (into the encoder)
//   idx / idx_valid / idx_ready : encoded index handshake (out of the encoder)
//   idx_last                    : current idx is the final set bit of a vector
//   count                       : popcount of the last accepted nonzero vector
//   empty                       : one-cycle pulse for an accepted all-zero vector
// The encoder connects to modport slave; its environment connects to master.
// ----------------------------------------------------------------------------
interface encoder_8_to_3_scanner_if #(
    parameter int SEL_BITS = 3
);
    localparam int REQ_W = 2**SEL_BITS;

    logic [REQ_W-1:0]    req;
    logic                req_valid;
    logic                req_ready;
    logic [SEL_BITS-1:0] idx;
    logic                idx_valid;
    logic                idx_ready;
    logic                idx_last;
    logic [SEL_BITS:0]   count;
    logic                empty;

    modport master (
        output req, req_valid, idx_ready,
        input  req_ready, idx, idx_valid, idx_last, count, empty
    );

    modport slave (
        input  req, req_valid, idx_ready,
        output req_ready, idx, idx_valid, idx_last, count, empty
    );
endinterface

// File: rtl/encoder_8_to_3_scanner.sv
// ----------------------------------------------------------------------------
// encoder_8_to_3_scanner
// Sequential priority encoder: accepts a 2**SEL_BITS request vector and emits
// the index of every set bit, one per output transfer, in priority order.
// Each served bit is cleared from an internal pending register.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   ena   : global enable; when low everything holds and no handshake completes
//   bus   : request/index handshake bundle (slave side)
// Parameters:
//   SEL_BITS      : index width (request width is 2**SEL_BITS)
//   PRIORITY_HIGH : 1 = highest set index first, 0 = lowest set index first
// ----------------------------------------------------------------------------
module encoder_8_to_3_scanner #(
    parameter int SEL_BITS      = 3,
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    encoder_8_to_3_scanner_if.slave  bus
);
    localparam int REQ_W = 2**SEL_BITS;

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [REQ_W-1:0]    pending_q, pending_d;
    logic [SEL_BITS-1:0] idx_q, idx_d;
    logic                idx_last_q, idx_last_d;
    logic [SEL_BITS:0]   count_q, count_d;
    logic                empty_q, empty_d;

    logic                req_ready_w;
    logic                idx_valid_w;
    logic                accept_w;
    logic                xfer_w;
    logic [REQ_W-1:0]    served_mask_w;

    // Index of the priority set bit; 0 when nothing is set.
    function automatic logic [SEL_BITS-1:0] prio_idx(input logic [REQ_W-1:0] v);
        logic [SEL_BITS-1:0] r;
        r = '0;
        if (PRIORITY_HIGH) begin
            for (int i = 0; i < REQ_W; i++) begin
                if (v[i]) r = i[SEL_BITS-1:0];
            end
        end else begin
            for (int i = REQ_W - 1; i >= 0; i--) begin
                if (v[i]) r = i[SEL_BITS-1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [SEL_BITS:0] popcount(input logic [REQ_W-1:0] v);
        logic [SEL_BITS:0] c;
        c = '0;
        for (int i = 0; i < REQ_W; i++) begin
            c = c + {{SEL_BITS{1'b0}}, v[i]};
        end
        return c;
    endfunction

    function automatic logic is_onehot(input logic [REQ_W-1:0] v);
        return popcount(v) == {{SEL_BITS{1'b0}}, 1'b1};
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            idx_q      <= '0;
            idx_last_q <= 1'b0;
            count_q    <= '0;
            empty_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            idx_q      <= idx_d;
            idx_last_q <= idx_last_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        count_d       = count_q;
        empty_d       = empty_q;
        served_mask_w = {{(REQ_W-1){1'b0}}, 1'b1} << idx_q;

        if (ena) begin
            empty_d = 1'b0;
            if (accept_w) begin
                if (bus.req != '0) begin
                    pending_d = bus.req;
                    count_d   = popcount(bus.req);
                    state_d   = SCAN;
                end else begin
                    empty_d = 1'b1;
                end
            end else if (xfer_w) begin
                pending_d = pending_q & ~served_mask_w;
                if (idx_last_q) state_d = IDLE;
            end
        end

        // idx/idx_last are registered views of the pending value being loaded,
        // so the first index is ready the cycle after accept.
        idx_d      = prio_idx(pending_d);
        idx_last_d = is_onehot(pending_d);
    end

    // Output logic; req_ready is forced low while reset is asserted.
    always_comb begin
        req_ready_w = (state_q == IDLE) && ena && rst_n;
        idx_valid_w = (state_q == SCAN);
        accept_w    = bus.req_valid && req_ready_w;
        xfer_w      = idx_valid_w && bus.idx_ready && ena;

        bus.req_ready = req_ready_w;
        bus.idx_valid = idx_valid_w;
        bus.idx       = idx_q;
        bus.idx_last  = idx_last_q;
        bus.count     = count_q;
        bus.empty     = empty_q;
    end
endmodule

// File: tb/tb_encoder_8_to_3_scanner.sv
// ----------------------------------------------------------------------------
// tb_encoder_8_to_3_scanner
// Directed bench: dut_hi uses high-first priority, dut_lo low-first priority.
// ----------------------------------------------------------------------------
module tb_encoder_8_to_3_scanner;
    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    always #5 clk = ~clk;

    encoder_8_to_3_scanner_if #(.SEL_BITS(3)) bus_hi();
    encoder_8_to_3_scanner_if #(.SEL_BITS(3)) bus_lo();

    encoder_8_to_3_scanner #(.SEL_BITS(3), .PRIORITY_HIGH(1'b1)) dut_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus_hi)
    );

    encoder_8_to_3_scanner #(.SEL_BITS(3), .PRIORITY_HIGH(1'b0)) dut_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus_lo)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    int exp_hi[4] = '{7, 5, 2, 1};
    int exp_en[3] = '{6, 5, 4};

    initial begin
        rst_n            = 1'b0;
        ena              = 1'b1;
        bus_hi.req       = '0;
        bus_hi.req_valid = 1'b0;
        bus_hi.idx_ready = 1'b1;
        bus_lo.req       = '0;
        bus_lo.req_valid = 1'b0;
        bus_lo.idx_ready = 1'b1;

        // Reset state
        #3;
        chk("rst_idx_valid", 32'(bus_hi.idx_valid), 0);
        chk("rst_idx",       32'(bus_hi.idx),       0);
        chk("rst_count",     32'(bus_hi.count),     0);
        chk("rst_empty",     32'(bus_hi.empty),     0);
        chk("rst_req_ready", 32'(bus_hi.req_ready), 0);
        repeat (2) step();
        chk("rst_hold_req_ready", 32'(bus_hi.req_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready", 32'(bus_hi.req_ready), 1);

        // Priority order, high first: 8'b1010_0110 -> 7,5,2,1
        step();
        bus_hi.req       = 8'hA6;
        bus_hi.req_valid = 1'b1;
        step();
        bus_hi.req_valid = 1'b0;
        chk("prio_count",     32'(bus_hi.count),     4);
        chk("prio_req_ready", 32'(bus_hi.req_ready), 0);
        for (int i = 0; i < 4; i++) begin
            chk("prio_valid", 32'(bus_hi.idx_valid), 1);
            chk("prio_idx",   32'(bus_hi.idx),       exp_hi[i]);
            chk("prio_last",  32'(bus_hi.idx_last),  (i == 3) ? 1 : 0);
            step();
        end
        chk("prio_done_valid", 32'(bus_hi.idx_valid), 0);
        chk("prio_done_ready", 32'(bus_hi.req_ready), 1);

        // Zero vector
        bus_hi.req       = 8'h00;
        bus_hi.req_valid = 1'b1;
        step();
        bus_hi.req_valid = 1'b0;
        chk("zero_empty",     32'(bus_hi.empty),     1);
        chk("zero_valid",     32'(bus_hi.idx_valid), 0);
        chk("zero_req_ready", 32'(bus_hi.req_ready), 1);
        chk("zero_count",     32'(bus_hi.count),     4);
        step();
        chk("zero_empty_drop", 32'(bus_hi.empty),     0);
        chk("zero_valid2",     32'(bus_hi.idx_valid), 0);

        // Backpressure with 8'h81
        bus_hi.idx_ready = 1'b0;
        bus_hi.req       = 8'h81;
        bus_hi.req_valid = 1'b1;
        step();
        bus_hi.req_valid = 1'b0;
        chk("bp_count", 32'(bus_hi.count), 2);
        for (int i = 0; i < 3; i++) begin
            chk("bp_idx",       32'(bus_hi.idx),       7);
            chk("bp_last",      32'(bus_hi.idx_last),  0);
            chk("bp_valid",     32'(bus_hi.idx_valid), 1);
            chk("bp_req_ready", 32'(bus_hi.req_ready), 0);
            step();
        end
        bus_hi.idx_ready = 1'b1;
        #1;
        chk("bp_rel_idx", 32'(bus_hi.idx), 7);
        step();
        chk("bp_idx0",  32'(bus_hi.idx),      0);
        chk("bp_last0", 32'(bus_hi.idx_last), 1);
        step();
        chk("bp_done_valid", 32'(bus_hi.idx_valid), 0);
        chk("bp_done_ready", 32'(bus_hi.req_ready), 1);

        // Enable drop mid-scan with 8'hF0
        bus_hi.req       = 8'hF0;
        bus_hi.req_valid = 1'b1;
        step();
        bus_hi.req_valid = 1'b0;
        chk("en_count", 32'(bus_hi.count), 4);
        chk("en_idx7",  32'(bus_hi.idx),   7);
        step();
        ena = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("en_hold_idx",   32'(bus_hi.idx),       6);
            chk("en_hold_valid", 32'(bus_hi.idx_valid), 1);
            step();
        end
        ena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("en_idx",  32'(bus_hi.idx),      exp_en[i]);
            chk("en_last", 32'(bus_hi.idx_last), (i == 2) ? 1 : 0);
            step();
        end
        chk("en_done_valid", 32'(bus_hi.idx_valid), 0);

        // Enable low in IDLE blocks accept
        ena = 1'b0;
        bus_hi.req       = 8'h0F;
        bus_hi.req_valid = 1'b1;
        #1;
        chk("en_idle_ready", 32'(bus_hi.req_ready), 0);
        step();
        chk("en_idle_noacc", 32'(bus_hi.idx_valid), 0);
        bus_hi.req_valid = 1'b0;
        ena = 1'b1;
        step();
        chk("en_idle_noacc2", 32'(bus_hi.idx_valid), 0);
        chk("en_idle_count",  32'(bus_hi.count),     4);

        // Reset mid-scan
        bus_hi.req       = 8'hF0;
        bus_hi.req_valid = 1'b1;
        step();
        bus_hi.req_valid = 1'b0;
        step();
        chk("mid_idx6", 32'(bus_hi.idx), 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus_hi.idx_valid), 0);
        chk("mid_rst_idx",   32'(bus_hi.idx),       0);
        chk("mid_rst_count", 32'(bus_hi.count),     0);
        chk("mid_rst_ready", 32'(bus_hi.req_ready), 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(bus_hi.req_ready), 1);
        step();
        chk("mid_rel_valid", 32'(bus_hi.idx_valid), 0);

        // Low-first order: 8'hFF -> 0..7
        bus_lo.req       = 8'hFF;
        bus_lo.req_valid = 1'b1;
        step();
        bus_lo.req_valid = 1'b0;
        chk("lo_count", 32'(bus_lo.count), 8);
        for (int i = 0; i < 8; i++) begin
            chk("lo_valid", 32'(bus_lo.idx_valid), 1);
            chk("lo_idx",   32'(bus_lo.idx),       i);
            chk("lo_last",  32'(bus_lo.idx_last),  (i == 7) ? 1 : 0);
            step();
        end
        chk("lo_done_valid", 32'(bus_lo.idx_valid), 0);
        chk("lo_done_ready", 32'(bus_lo.req_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
